// File: rtl/syst_node_pkg.sv
// syst_node_pkg: shared bounds, complex-pair type and width-generic saturation helpers
package syst_node_pkg;
  localparam int MUL_PIPE_MIN = 1;
  localparam int MUL_PIPE_MAX = 3;
  localparam int SAT_W = 128;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;
  function automatic logic sat_ovf(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    return (v > hi) || (v < ~hi);
  endfunction
  function automatic logic signed [SAT_W-1:0] sat_val(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    return (v > hi) ? hi : (v < ~hi) ? ~hi : v;
  endfunction
endpackage

// File: rtl/syst_node_cplx_mult.sv
// cplx_mult_pipe: exact complex multiply with NP enable-gated stages and a delayed sideband
module cplx_mult_pipe
  import syst_node_pkg::*;
#(
  parameter int XW = 16,
  parameter int WW = 16,
  parameter int DW = 64,
  parameter int NP = 2,
  localparam int PW = XW + WW + 1
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 enable,
  input  logic signed [XW-1:0] x_re,
  input  logic signed [XW-1:0] x_im,
  input  logic signed [WW-1:0] w_re,
  input  logic signed [WW-1:0] w_im,
  input  logic [DW-1:0]        side_i,
  input  logic                 valid_i,
  output logic signed [PW-1:0] p_re,
  output logic signed [PW-1:0] p_im,
  output logic [DW-1:0]        side_o,
  output logic                 valid_o
);
  localparam int NS = NP < MUL_PIPE_MIN ? MUL_PIPE_MIN : NP > MUL_PIPE_MAX ? MUL_PIPE_MAX : NP;
  logic signed [PW-1:0] xr, xi, wr, wi, re0, im0;
  logic signed [PW-1:0] re_q [NS];
  logic signed [PW-1:0] im_q [NS];
  logic [DW-1:0] sd_q [NS];
  logic [NS-1:0] v_q;
  assign xr = PW'(x_re);
  assign xi = PW'(x_im);
  assign wr = PW'(w_re);
  assign wi = PW'(w_im);
  assign re0 = xr * wr - xi * wi;
  assign im0 = xr * wi + xi * wr;
  always_ff @(posedge clk)
    if (!arstn) begin
      for (int i = 0; i < NS; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
        sd_q[i] <= '0;
        v_q[i] <= 1'b0;
      end
    end else if (enable) begin
      re_q[0] <= re0;
      im_q[0] <= im0;
      sd_q[0] <= side_i;
      v_q[0] <= valid_i;
      for (int i = 1; i < NS; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
        sd_q[i] <= sd_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
  assign p_re = re_q[NS-1];
  assign p_im = im_q[NS-1];
  assign side_o = sd_q[NS-1];
  assign valid_o = v_q[NS-1];
endmodule

// File: rtl/syst_node_cplx.sv
// syst_node_cplx: systolic complex MAC node with shadow/active weight chain and saturating sum
module syst_node_cplx
  import syst_node_pkg::*;
#(
  parameter int W_WIDTH  = 16,
  parameter int X_WIDTH  = 16,
  parameter int SI_WIDTH = 32,
  parameter int SO_WIDTH = 32,
  parameter int MUL_PIPE = 2,
  parameter int SAT_EN   = 1
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       enable,
  input  logic signed [W_WIDTH-1:0]  w_re_i,
  input  logic signed [W_WIDTH-1:0]  w_im_i,
  input  logic                       w_valid_i,
  input  logic                       w_swap,
  output logic signed [W_WIDTH-1:0]  w_re_o,
  output logic signed [W_WIDTH-1:0]  w_im_o,
  output logic                       w_valid_o,
  input  logic signed [X_WIDTH-1:0]  x_re_i,
  input  logic signed [X_WIDTH-1:0]  x_im_i,
  input  logic                       valid_x_i,
  input  logic signed [SI_WIDTH-1:0] psumm_re_i,
  input  logic signed [SI_WIDTH-1:0] psumm_im_i,
  input  logic                       valid_psumm_i,
  output logic signed [SO_WIDTH-1:0] psumm_re_o,
  output logic signed [SO_WIDTH-1:0] psumm_im_o,
  output logic                       valid_o,
  output logic signed [X_WIDTH-1:0]  x_re_o,
  output logic signed [X_WIDTH-1:0]  x_im_o,
  output logic                       valid_x_o,
  output logic                       sat_o,
  input  logic                       clr_sat
);
  localparam int PW = X_WIDTH + W_WIDTH + 1;
  logic signed [W_WIDTH-1:0] sh_re, sh_im, ac_re, ac_im;
  logic signed [PW-1:0] p_re, p_im;
  logic [2*SI_WIDTH-1:0] ps_d;
  logic mv, ovf;
  logic signed [SAT_W-1:0] s_re, s_im;
  logic signed [SO_WIDTH-1:0] r_re, r_im;
  cplx_mult_pipe #(.XW(X_WIDTH), .WW(W_WIDTH), .DW(2*SI_WIDTH), .NP(MUL_PIPE)) u_mult (
    .clk(clk), .arstn(arstn), .enable(enable),
    .x_re(x_re_i), .x_im(x_im_i), .w_re(ac_re), .w_im(ac_im),
    .side_i({psumm_re_i, psumm_im_i}), .valid_i(valid_x_i && valid_psumm_i),
    .p_re(p_re), .p_im(p_im), .side_o(ps_d), .valid_o(mv)
  );
  always_comb begin
    s_re = SAT_W'(p_re) + SAT_W'($signed(ps_d[2*SI_WIDTH-1:SI_WIDTH]));
    s_im = SAT_W'(p_im) + SAT_W'($signed(ps_d[SI_WIDTH-1:0]));
    r_re = SO_WIDTH'(SAT_EN != 0 ? sat_val(s_re, SO_WIDTH) : s_re);
    r_im = SO_WIDTH'(SAT_EN != 0 ? sat_val(s_im, SO_WIDTH) : s_im);
    ovf = (SAT_EN != 0) && (sat_ovf(s_re, SO_WIDTH) || sat_ovf(s_im, SO_WIDTH));
  end
  // weight chain runs free of enable; only the swap into active is gated
  always_ff @(posedge clk)
    if (!arstn) begin
      sh_re <= '0;
      sh_im <= '0;
      ac_re <= '0;
      ac_im <= '0;
      w_re_o <= '0;
      w_im_o <= '0;
      w_valid_o <= 1'b0;
    end else begin
      w_valid_o <= w_valid_i;
      if (w_valid_i) begin
        sh_re <= w_re_i;
        sh_im <= w_im_i;
        w_re_o <= sh_re;
        w_im_o <= sh_im;
      end
      if (w_swap && enable) begin
        ac_re <= sh_re;
        ac_im <= sh_im;
      end
    end
  always_ff @(posedge clk)
    if (!arstn) begin
      x_re_o <= '0;
      x_im_o <= '0;
      valid_x_o <= 1'b0;
      psumm_re_o <= '0;
      psumm_im_o <= '0;
      valid_o <= 1'b0;
      sat_o <= 1'b0;
    end else begin
      if (enable) begin
        x_re_o <= x_re_i;
        x_im_o <= x_im_i;
        valid_x_o <= valid_x_i;
        valid_o <= mv;
        if (mv) begin
          psumm_re_o <= r_re;
          psumm_im_o <= r_im;
        end
      end
      sat_o <= (enable && mv && ovf) ? 1'b1 : clr_sat ? 1'b0 : sat_o;
    end
endmodule

// File: tb/tb_syst_node_cplx.sv
// tb_syst_node_cplx: directed self-checking bench for syst_node_cplx
module tb_syst_node_cplx;
  import syst_node_pkg::*;
  logic clk = 1'b0;
  logic arstn, enable, w_valid, w_swap, vx, vps, clr_sat;
  cplx_t w, x;
  logic signed [31:0] ps_re, ps_im;
  logic signed [15:0] a_w_re_o, a_w_im_o, b_w_re_o, b_w_im_o, c_w_re_o, c_w_im_o;
  logic a_w_valid_o, b_w_valid_o, c_w_valid_o;
  logic signed [31:0] a_ps_re, a_ps_im, b_ps_re, b_ps_im, c_ps_re, c_ps_im;
  logic a_valid_o, b_valid_o, c_valid_o;
  logic signed [15:0] a_x_re, a_x_im, b_x_re, b_x_im, c_x_re, c_x_im;
  logic a_vx_o, b_vx_o, c_vx_o, a_sat, b_sat, c_sat;
  int nvec = 0, nerr = 0;

  syst_node_cplx #(.SAT_EN(1)) dut (
    .clk(clk), .arstn(arstn), .enable(enable),
    .w_re_i(w.re), .w_im_i(w.im), .w_valid_i(w_valid), .w_swap(w_swap),
    .w_re_o(a_w_re_o), .w_im_o(a_w_im_o), .w_valid_o(a_w_valid_o),
    .x_re_i(x.re), .x_im_i(x.im), .valid_x_i(vx),
    .psumm_re_i(ps_re), .psumm_im_i(ps_im), .valid_psumm_i(vps),
    .psumm_re_o(a_ps_re), .psumm_im_o(a_ps_im), .valid_o(a_valid_o),
    .x_re_o(a_x_re), .x_im_o(a_x_im), .valid_x_o(a_vx_o),
    .sat_o(a_sat), .clr_sat(clr_sat)
  );
  syst_node_cplx #(.SAT_EN(0)) dut_w (
    .clk(clk), .arstn(arstn), .enable(enable),
    .w_re_i(w.re), .w_im_i(w.im), .w_valid_i(w_valid), .w_swap(w_swap),
    .w_re_o(b_w_re_o), .w_im_o(b_w_im_o), .w_valid_o(b_w_valid_o),
    .x_re_i(x.re), .x_im_i(x.im), .valid_x_i(vx),
    .psumm_re_i(ps_re), .psumm_im_i(ps_im), .valid_psumm_i(vps),
    .psumm_re_o(b_ps_re), .psumm_im_o(b_ps_im), .valid_o(b_valid_o),
    .x_re_o(b_x_re), .x_im_o(b_x_im), .valid_x_o(b_vx_o),
    .sat_o(b_sat), .clr_sat(clr_sat)
  );
  syst_node_cplx #(.SAT_EN(1)) dn (
    .clk(clk), .arstn(arstn), .enable(enable),
    .w_re_i(a_w_re_o), .w_im_i(a_w_im_o), .w_valid_i(a_w_valid_o), .w_swap(w_swap),
    .w_re_o(c_w_re_o), .w_im_o(c_w_im_o), .w_valid_o(c_w_valid_o),
    .x_re_i(x.re), .x_im_i(x.im), .valid_x_i(vx),
    .psumm_re_i(ps_re), .psumm_im_i(ps_im), .valid_psumm_i(vps),
    .psumm_re_o(c_ps_re), .psumm_im_o(c_ps_im), .valid_o(c_valid_o),
    .x_re_o(c_x_re), .x_im_o(c_x_im), .valid_x_o(c_vx_o),
    .sat_o(c_sat), .clr_sat(clr_sat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    w_valid = 1'b0; w_swap = 1'b0; vx = 1'b0; vps = 1'b0; clr_sat = 1'b0; enable = 1'b1;
    x = '0; ps_re = 0; ps_im = 0;
  endtask

  task automatic load_w(input int re, input int im);
    w.re = 16'(re); w.im = 16'(im); w_valid = 1'b1;
    tick;
    w_valid = 1'b0; w_swap = 1'b1;
    tick;
    w_swap = 1'b0;
  endtask

  task automatic push(input int xr, input int xi, input int pr, input int pi);
    x.re = 16'(xr); x.im = 16'(xi); ps_re = pr; ps_im = pi; vx = 1'b1; vps = 1'b1;
    tick;
    idle;
  endtask

  task automatic test_reset;
    idle;
    arstn = 1'b0; enable = 1'b0; vx = 1'b1; vps = 1'b1; w_valid = 1'b1; x.re = 16'sd9;
    tick;
    tick;
    nvec++; if (a_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid_o got %0d exp 0", a_valid_o); end
    nvec++; if (a_ps_re !== 32'sd0) begin nerr++; $display("FAIL rst_psumm_re got %0d exp 0", a_ps_re); end
    nvec++; if (a_x_re !== 16'sd0 || a_vx_o !== 1'b0) begin nerr++; $display("FAIL rst_x_fwd got %0d/%0d exp 0/0", a_x_re, a_vx_o); end
    nvec++; if (a_w_valid_o !== 1'b0 || a_w_re_o !== 16'sd0) begin nerr++; $display("FAIL rst_w_chain got %0d/%0d exp 0/0", a_w_valid_o, a_w_re_o); end
    nvec++; if (a_sat !== 1'b0) begin nerr++; $display("FAIL rst_sat got %0d exp 0", a_sat); end
    idle;
    arstn = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    w.re = 16'sd3; w.im = -16'sd2; w_valid = 1'b1;
    tick;
    nvec++; if (a_w_valid_o !== 1'b1 || a_w_re_o !== 16'sd0) begin nerr++; $display("FAIL chain_fwd got %0d/%0d exp 1/0", a_w_valid_o, a_w_re_o); end
    w_valid = 1'b0; w_swap = 1'b1;
    tick;
    nvec++; if (a_w_valid_o !== 1'b0) begin nerr++; $display("FAIL chain_strobe got %0d exp 0", a_w_valid_o); end
    w_swap = 1'b0;
    push(5, 7, 100, -50);
    nvec++; if (a_x_re !== 16'sd5 || a_x_im !== 16'sd7 || a_vx_o !== 1'b1) begin nerr++; $display("FAIL basic_xfwd got %0d,%0d,%0d exp 5,7,1", a_x_re, a_x_im, a_vx_o); end
    tick;
    nvec++; if (a_valid_o !== 1'b0) begin nerr++; $display("FAIL basic_early got %0d exp 0", a_valid_o); end
    tick;
    // re = 15 + 14 = 29, im = -10 + 21 = 11
    nvec++; if (a_valid_o !== 1'b1 || a_ps_re !== 32'sd129 || a_ps_im !== -32'sd39) begin nerr++; $display("FAIL basic_sum got %0d,%0d,%0d exp 1,129,-39", a_valid_o, a_ps_re, a_ps_im); end
    tick;
    nvec++; if (a_valid_o !== 1'b0 || a_ps_re !== 32'sd129) begin nerr++; $display("FAIL basic_hold got %0d,%0d exp 0,129", a_valid_o, a_ps_re); end
  endtask

  task automatic test_fwd;
    x.re = 16'sd11; x.im = -16'sd4; vx = 1'b1; vps = 1'b0;
    tick;
    nvec++; if (a_vx_o !== 1'b1 || a_x_re !== 16'sd11 || a_x_im !== -16'sd4) begin nerr++; $display("FAIL fwd_x got %0d,%0d,%0d exp 1,11,-4", a_vx_o, a_x_re, a_x_im); end
    idle;
    for (int i = 0; i < 3; i++) begin
      tick;
      nvec++; if (a_valid_o !== 1'b0) begin nerr++; $display("FAIL fwd_no_valid got %0d exp 0", a_valid_o); end
    end
    nvec++; if (a_vx_o !== 1'b0) begin nerr++; $display("FAIL fwd_vx_drop got %0d exp 0", a_vx_o); end
  endtask

  task automatic test_sat;
    load_w(32767, 0);
    push(32767, 0, 2147482648, 0);
    tick;
    tick;
    nvec++; if (a_ps_re !== 32'sh7FFFFFFF || a_ps_im !== 32'sd0) begin nerr++; $display("FAIL sat_pos got %0d,%0d exp 2147483647,0", a_ps_re, a_ps_im); end
    nvec++; if (a_sat !== 1'b1) begin nerr++; $display("FAIL sat_flag got %0d exp 1", a_sat); end
    nvec++; if (b_ps_re !== -32'sd1073808359 || b_sat !== 1'b0) begin nerr++; $display("FAIL wrap_sum got %0d,%0d exp -1073808359,0", b_ps_re, b_sat); end
    clr_sat = 1'b1;
    tick;
    clr_sat = 1'b0;
    nvec++; if (a_sat !== 1'b0) begin nerr++; $display("FAIL sat_clear got %0d exp 0", a_sat); end
    push(-32767, 0, -2147482648, 0);
    clr_sat = 1'b1;
    tick;
    tick;
    nvec++; if (a_ps_re !== 32'sh80000000) begin nerr++; $display("FAIL sat_neg got %0d exp -2147483648", a_ps_re); end
    nvec++; if (a_sat !== 1'b1) begin nerr++; $display("FAIL sat_set_wins got %0d exp 1", a_sat); end
    tick;
    nvec++; if (a_sat !== 1'b0) begin nerr++; $display("FAIL sat_clr_after got %0d exp 0", a_sat); end
    clr_sat = 1'b0;
  endtask

  task automatic test_stall;
    int s, r;
    logic en;
    s = 1; r = 0;
    load_w(2, 1);
    for (int c = 0; c < 200 && r < 8; c++) begin
      en = (c % 3 == 0);
      enable = en; vx = (s <= 8); vps = (s <= 8);
      x.re = 16'(s); x.im = 16'(-s); ps_re = 10 * s; ps_im = 0;
      tick;
      if (en) begin
        if (s <= 8) s++;
        if (a_valid_o) begin
          r++;
          // re = 2s + s, im = s - 2s
          nvec++; if (a_ps_re !== 32'(13 * r) || a_ps_im !== 32'(-r)) begin nerr++; $display("FAIL stall_res%0d got %0d,%0d exp %0d,%0d", r, a_ps_re, a_ps_im, 13 * r, -r); end
        end
      end
    end
    nvec++; if (r !== 8) begin nerr++; $display("FAIL stall_count got %0d exp 8", r); end
    idle;
  endtask

  task automatic test_chain;
    arstn = 1'b0;
    tick;
    arstn = 1'b1;
    idle;
    w.re = 16'sd1; w.im = 16'sd0; w_valid = 1'b1;
    tick;
    w.re = 16'sd2;
    tick;
    w_valid = 1'b0;
    tick;
    w_swap = 1'b1;
    tick;
    w_swap = 1'b0;
    push(1, 0, 0, 0);
    tick;
    tick;
    nvec++; if (a_ps_re !== 32'sd2) begin nerr++; $display("FAIL chain_up got %0d exp 2", a_ps_re); end
    nvec++; if (c_ps_re !== 32'sd1) begin nerr++; $display("FAIL chain_down got %0d exp 1", c_ps_re); end
    w.re = 16'sd5; w_valid = 1'b1; w_swap = 1'b1;
    tick;
    w.re = 16'sd7;
    tick;
    w_valid = 1'b0; w_swap = 1'b0;
    nvec++; if (a_w_re_o !== 16'sd5) begin nerr++; $display("FAIL coinc_fwd got %0d exp 5", a_w_re_o); end
    push(1, 0, 0, 0);
    tick;
    tick;
    nvec++; if (a_ps_re !== 32'sd5) begin nerr++; $display("FAIL coinc_active got %0d exp 5", a_ps_re); end
  endtask

  task automatic test_midreset;
    load_w(1, 0);
    x.re = 16'sd4; ps_re = 1; vx = 1'b1; vps = 1'b1;
    tick;
    x.re = 16'sd6;
    tick;
    idle;
    arstn = 1'b0;
    tick;
    nvec++; if (a_valid_o !== 1'b0 || a_ps_re !== 32'sd0 || a_ps_im !== 32'sd0) begin nerr++; $display("FAIL mrst_sum got %0d,%0d,%0d exp 0,0,0", a_valid_o, a_ps_re, a_ps_im); end
    nvec++; if (a_vx_o !== 1'b0 || a_x_re !== 16'sd0 || a_w_valid_o !== 1'b0 || a_sat !== 1'b0) begin nerr++; $display("FAIL mrst_misc got %0d,%0d,%0d,%0d exp 0,0,0,0", a_vx_o, a_x_re, a_w_valid_o, a_sat); end
    arstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      nvec++; if (a_valid_o !== 1'b0) begin nerr++; $display("FAIL mrst_stale got %0d exp 0", a_valid_o); end
    end
    push(3, 0, 1, 0);
    tick;
    tick;
    nvec++; if (a_valid_o !== 1'b1 || a_ps_re !== 32'sd1) begin nerr++; $display("FAIL mrst_weight_clr got %0d,%0d exp 1,1", a_valid_o, a_ps_re); end
  endtask

  initial begin
    idle;
    arstn = 1'b0;
    w = '0;
    test_reset;
    test_basic;
    test_fwd;
    test_sat;
    test_stall;
    test_chain;
    test_midreset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
